// File: rtl/ped_sched.sv
// ----------------------------------------------------------------------------
// ped_sched
//
// Round-robin scheduler that shares one slow resource among N requesters.
// Each one-cycle request pulse is latched as a pending bit. Pending requests
// are granted one at a time through a start/done handshake.
//
// Handshake: when a requester is chosen, start pulses high for exactly one
// cycle while grant shows the one-hot owner. grant and busy stay high until
// the resource answers with done (sampled only in WAIT). Afterwards the block
// spends one IDLE cycle before it can grant again.
//
// Optional feature: define PED_SCHED_TIMEOUT_EN to build a wait counter that
// aborts a grant after TIMEOUT cycles in WAIT without done. Without the macro
// no counter is built and timeout is tied to 0.
//
// Parameters:
//   N          number of requesters (2..8)
//   TIMEOUT    WAIT cycles allowed before abort (timeout build only, >= 2)
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   req_pulse  one-cycle request pulses, bit i = requester i
//   done       resource finished the granted job
//   grant      one-hot owner of the resource, 0 when idle
//   start      one-cycle pulse at the start of each grant
//   busy       high in START and WAIT
//   pending    latched, not-yet-granted requests
//   drop       one-cycle pulse: a request hit an already-set pending bit
//   timeout    one-cycle pulse: a grant was aborted
//   fsm_state  current FSM state (0=IDLE, 1=START, 2=WAIT), for observation
// ----------------------------------------------------------------------------
module ped_sched #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_pulse,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         start,
    output logic         busy,
    output logic [N-1:0] pending,
    output logic         drop,
    output logic         timeout,
    output logic [1:0]   fsm_state
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;          // last granted requester; also the current owner

`ifdef PED_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    logic [PW-1:0] winner;
    logic [PW-1:0] idx;
    logic          found;
    logic          any_pending;
    logic          start_en;
    logic [N-1:0]  clr;
    logic [N-1:0]  pending_next;
    logic          drop_next;

    // Round-robin search: offsets 1..N from ptr, first set pending bit wins.
    // Offset N comes back to ptr itself so a lone request from the last owner
    // is still served.
    always_comb begin
        winner = ptr;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_pending = |pending;
    assign start_en    = (state == IDLE) && any_pending;
    assign clr         = start_en ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;

    // A new pulse on the clearing edge re-pends the requester instead of
    // being dropped; otherwise a pulse on a set bit is lost and reported.
    assign pending_next = (pending & ~clr) | req_pulse;
    assign drop_next    = |(req_pulse & pending & ~clr);

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            ptr     <= PW'(N - 1);
            grant   <= '0;
            start   <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
`ifdef PED_SCHED_TIMEOUT_EN
            timeout  <= 1'b0;
            wait_cnt <= '0;
`endif
        end else begin
            pending <= pending_next;
            drop    <= drop_next;
            start   <= 1'b0;
`ifdef PED_SCHED_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        state <= START;
                        ptr   <= winner;
                        grant <= clr;
                        start <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef PED_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (done) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
`ifdef PED_SCHED_TIMEOUT_EN
                    // wait_cnt holds the number of WAIT cycles already
                    // completed, so TIMEOUT-1 marks the last allowed cycle.
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        state   <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else if (wait_cnt != TW'(TIMEOUT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef PED_SCHED_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ped_sched.sv
// ----------------------------------------------------------------------------
// tb_ped_sched
//
// Directed bench for ped_sched (N=4, TIMEOUT=16). Expected grants are queued
// when requests are driven and compared whenever start is seen.
// ----------------------------------------------------------------------------
module tb_ped_sched;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_pulse;
    logic         done;
    logic [N-1:0] grant;
    logic         start;
    logic         busy;
    logic [N-1:0] pending;
    logic         drop;
    logic         timeout;
    logic [1:0]   fsm_state;

    int checks;
    int errors;
    int start_cnt;

    logic [N-1:0] exp_q[$];

    ped_sched #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_pulse (req_pulse),
        .done      (done),
        .grant     (grant),
        .start     (start),
        .busy      (busy),
        .pending   (pending),
        .drop      (drop),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_pulse = '0;
        done      = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (start !== 1'b1 && n < budget);
        check("wait_start", {31'd0, start}, 32'd1);
    endtask

    // Hold done high until every queued grant has been served.
    task automatic serve_all(input int budget);
        int n;
        n = 0;
        done = 1'b1;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        done = 1'b0;
        check("serve_all_drained", {31'd0, (exp_q.size() == 0 && busy === 1'b0)}, 32'd1);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && start === 1'b1) begin
            logic [N-1:0] e;
            start_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_grant observed=%0h expected=none", grant);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (grant === e) else begin
                    errors++;
                    $error("FAIL grant_order observed=%0h expected=%0h", grant, e);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int st0;
        logic bad;
        checks    = 0;
        errors    = 0;
        start_cnt = 0;
        rst       = 1'b1;
        req_pulse = '0;
        done      = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_grant",   32'(grant),     32'h0);
        check("rst_start",   32'(start),     32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_pending", 32'(pending),   32'h0);
        check("rst_drop",    32'(drop),      32'h0);
        check("rst_timeout", 32'(timeout),   32'h0);
        check("rst_state",   32'(fsm_state), 32'h0);
        rst = 1'b0;
        tick();

        // A: single request latency and done release
        req_pulse = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        req_pulse = '0;
        check("a_pending", 32'(pending), 32'h1);
        check("a_no_start_yet", 32'(start), 32'h0);
        tick();
        check("a_start", 32'(start), 32'h1);
        check("a_grant", 32'(grant), 32'h1);
        check("a_busy", 32'(busy), 32'h1);
        check("a_pending_clr", 32'(pending), 32'h0);
        tick();
        check("a_start_one_cycle", 32'(start), 32'h0);
        check("a_busy_wait", 32'(busy), 32'h1);
        tick();
        tick();
        check("a_grant_held", 32'(grant), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("a_grant_released", 32'(grant), 32'h0);
        check("a_busy_released", 32'(busy), 32'h0);

        // B: all requesters at once, fresh reset -> 0,1,2,3
        do_reset();
        st0 = start_cnt;
        req_pulse = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        tick();
        req_pulse = '0;
        check("b_pending_all", 32'(pending), 32'hf);
        check("b_no_drop", 32'(drop), 32'h0);
        serve_all(60);
        check("b_start_count", 32'(start_cnt - st0), 32'd4);
        check("b_pending_empty", 32'(pending), 32'h0);

        // C: requester 1 in WAIT, then 3 and 0 arrive -> 3 before 0
        req_pulse = 4'b0010;
        exp_q.push_back(4'b0010);
        tick();
        req_pulse = '0;
        wait_start(10);
        tick();
        req_pulse = 4'b1001;
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        tick();
        req_pulse = '0;
        check("c_pending", 32'(pending), 32'h9);
        repeat (3) tick();
        check("c_grant_held", 32'(grant), 32'h2);
        serve_all(60);

        // D: repeated requests on a pending bit are dropped
        req_pulse = 4'b0010;
        exp_q.push_back(4'b0010);
        tick();
        req_pulse = '0;
        wait_start(10);
        tick();
        req_pulse = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        check("d_first_no_drop", 32'(drop), 32'h0);
        check("d_pending", 32'(pending), 32'h4);
        tick();
        check("d_drop1", 32'(drop), 32'h1);
        tick();
        check("d_drop2", 32'(drop), 32'h1);
        req_pulse = '0;
        tick();
        check("d_drop_end", 32'(drop), 32'h0);
        check("d_pending_one", 32'(pending), 32'h4);
        serve_all(60);
        repeat (5) tick();
        check("d_no_regrant", 32'(pending), 32'h0);

        // E: asynchronous reset mid-grant
        req_pulse = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        req_pulse = '0;
        wait_start(10);
        tick();
        req_pulse = 4'b1001;
        tick();
        req_pulse = '0;
        check("e_grant_before", 32'(grant), 32'h4);
        check("e_pending_before", 32'(pending), 32'h9);
        #2;
        rst = 1'b1;
        #1;
        check("e_rst_grant", 32'(grant), 32'h0);
        check("e_rst_busy", 32'(busy), 32'h0);
        check("e_rst_start", 32'(start), 32'h0);
        check("e_rst_pending", 32'(pending), 32'h0);
        check("e_rst_state", 32'(fsm_state), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        req_pulse = 4'b1001;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1000);
        tick();
        req_pulse = '0;
        serve_all(60);

        // F: no done for a long time
        req_pulse = 4'b0110;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        tick();
        req_pulse = '0;
        wait_start(10);
        bad = 1'b0;
`ifdef PED_SCHED_TIMEOUT_EN
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (timeout !== 1'b0 || grant !== 4'b0010) bad = 1'b1;
        end
        check("f_wait_quiet", 32'(bad), 32'h0);
        tick();
        check("f_timeout_pulse", 32'(timeout), 32'h1);
        check("f_timeout_grant", 32'(grant), 32'h0);
        check("f_timeout_busy", 32'(busy), 32'h0);
        tick();
        check("f_timeout_one_cycle", 32'(timeout), 32'h0);
        check("f_next_start", 32'(start), 32'h1);
        check("f_next_grant", 32'(grant), 32'h4);
`else
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout !== 1'b0 || grant !== 4'b0010) bad = 1'b1;
        end
        check("f_held_no_timeout", 32'(bad), 32'h0);
        check("f_busy_held", 32'(busy), 32'h1);
`endif
        serve_all(60);
        check("f_pending_empty", 32'(pending), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
